// File: rtl/sam_vram_pkg.sv
// Shared types and defaults for the Sam Coupe VRAM arbiter.
package sam_vram_pkg;

  typedef enum logic [1:0] {IDLE, VID1, VID2, CPU} arb_state_t;

  localparam int VRAM_AW = 19;

endpackage

// File: rtl/vram_arb_stats.sv
// Saturating 16-bit count of CPU wait cycles, cleared by reset or i_clr.
module vram_arb_stats
  import sam_vram_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  // Count stalled cycles and hold at all-ones instead of wrapping.
  always_ff @(posedge clk_sys) begin
    if (reset || i_clr) begin
      r_cnt <= 16'd0;
    end else if (i_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/vram_arbiter.sv
// Sequences video fetch pairs and CPU byte accesses onto one 16-bit VRAM port.
// Define VRAM_ARB_STATS_EN to add stats_clr and the cpu_wait_cnt counter.
module vram_arbiter
  import sam_vram_pkg::*;
#(
  parameter int VID_BUDGET = 24,
  parameter int AW         = VRAM_AW
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] vid_addr1,
  input  logic [AW-1:0] vid_addr2,
  input  logic          vid_rd,
  output logic [15:0]   vid_dout1,
  output logic [15:0]   vid_dout2,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_req,
  output logic          ram_we,
  output logic [1:0]    ram_be,
  output logic [15:0]   ram_din,
  input  logic [15:0]   ram_dout,
  input  logic          ram_ack,
`ifdef VRAM_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   cpu_wait_cnt,
`endif
  output logic          overrun
);

  localparam int BW = $clog2(VID_BUDGET + 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic          r_vid_rd_d;
  logic          r_vid_pend;
  logic          r_vid_again;
  logic [BW-1:0] r_budget;

  logic          w_toggle;
  logic          w_vid1_done;
  logic          w_vid_done;
  logic          w_cpu_done;
  logic          w_cpu_ok;
  logic [AW-1:0] w_ram_addr;
  logic          w_ram_req;
  logic          w_ram_we;
  logic [1:0]    w_ram_be;
  logic [15:0]   w_ram_din;

  assign w_toggle    = vid_rd ^ r_vid_rd_d;
  assign w_vid1_done = (r_state == VID1) && ram_ack;
  assign w_vid_done  = (r_state == VID2) && ram_ack;
  assign w_cpu_done  = (r_state == CPU) && ram_ack;
  // The cycle showing cpu_ack still carries the finished request's level.
  assign w_cpu_ok    = cpu_req && !cpu_ack;
  assign cpu_wait    = cpu_req & ~cpu_ack;

  // Next-state selection; a fresh toggle holds the CPU off so video wins ties.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_vid_pend) begin
          w_state_nxt = VID1;
        end else if (w_cpu_ok && !w_toggle) begin
          w_state_nxt = CPU;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      VID1: begin
        if (ram_ack) begin
          w_state_nxt = VID2;
        end else begin
          w_state_nxt = VID1;
        end
      end
      VID2: begin
        if (ram_ack) begin
          w_state_nxt = w_cpu_ok ? CPU : IDLE;
        end else begin
          w_state_nxt = VID2;
        end
      end
      CPU: begin
        if (ram_ack) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = CPU;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM port values for the state being entered, registered below.
  always_comb begin
    w_ram_addr = '0;
    w_ram_req  = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_be   = 2'b00;
    w_ram_din  = 16'h0000;
    case (w_state_nxt)
      VID1: begin
        w_ram_addr = vid_addr1;
        w_ram_req  = 1'b1;
        w_ram_be   = 2'b11;
      end
      VID2: begin
        w_ram_addr = vid_addr2;
        w_ram_req  = 1'b1;
        w_ram_be   = 2'b11;
      end
      CPU: begin
        w_ram_addr = cpu_addr[AW:1];
        w_ram_req  = 1'b1;
        w_ram_we   = cpu_we;
        w_ram_din  = {cpu_din, cpu_din};
        if (cpu_we) begin
          w_ram_be = cpu_addr[0] ? 2'b10 : 2'b01;
        end else begin
          w_ram_be = 2'b11;
        end
      end
      default: begin
        w_ram_addr = '0;
        w_ram_req  = 1'b0;
      end
    endcase
  end

  // State, RAM port and completion outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= IDLE;
      ram_addr  <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= 2'b00;
      ram_din   <= 16'h0000;
      vid_dout1 <= 16'h0000;
      vid_dout2 <= 16'h0000;
      vid_valid <= 1'b0;
      cpu_dout  <= 8'h00;
      cpu_ack   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      ram_addr  <= w_ram_addr;
      ram_req   <= w_ram_req;
      ram_we    <= w_ram_we;
      ram_be    <= w_ram_be;
      ram_din   <= w_ram_din;
      vid_valid <= w_vid_done;
      cpu_ack   <= w_cpu_done;
      vid_dout1 <= w_vid1_done ? ram_dout : vid_dout1;
      vid_dout2 <= w_vid_done ? ram_dout : vid_dout2;
      if (w_cpu_done) begin
        cpu_dout <= cpu_addr[0] ? ram_dout[15:8] : ram_dout[7:0];
      end else begin
        cpu_dout <= cpu_dout;
      end
    end
  end

  // Toggle tracking, pending requests, deadline budget and sticky overrun.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_vid_rd_d  <= vid_rd;
      r_vid_pend  <= 1'b0;
      r_vid_again <= 1'b0;
      r_budget    <= '0;
      overrun     <= 1'b0;
    end else begin
      r_vid_rd_d <= vid_rd;
      if (r_vid_pend && !w_vid_done) begin
        if (r_budget != '0) begin
          r_budget <= r_budget - BW'(1);
        end else begin
          r_budget <= r_budget;
        end
        if (r_budget <= BW'(1)) begin
          overrun <= 1'b1;
        end else begin
          overrun <= overrun;
        end
      end else begin
        r_budget <= r_budget;
      end
      if (w_vid_done) begin
        r_vid_pend  <= w_toggle || r_vid_again;
        r_vid_again <= w_toggle && r_vid_again;
        if (w_toggle || r_vid_again) begin
          r_budget <= BW'(VID_BUDGET);
        end else begin
          r_budget <= r_budget;
        end
      end else if (w_toggle && r_vid_pend) begin
        overrun     <= 1'b1;
        r_vid_again <= 1'b1;
      end else if (w_toggle) begin
        r_vid_pend <= 1'b1;
        r_budget   <= BW'(VID_BUDGET);
      end else begin
        r_vid_pend <= r_vid_pend;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  vram_arb_stats u_stats (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_clr   (stats_clr),
    .i_inc   (cpu_wait),
    .o_cnt   (cpu_wait_cnt)
  );
`endif

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM sequencer between the Sam Coupe video controller and the Z80 memory bus. It converts the video controller's toggle-style fetch request (two 16-bit words per 8-pixel column) into back-to-back RAM reads, and interleaves CPU byte reads and writes into the remaining bandwidth. It also drives the CPU wait handshake. It sits in front of the 16-bit video RAM, whose completion is signalled by an ack.

## Interface
Parameters:
- VID_BUDGET, 24, maximum clk_sys cycles from video toggle detection to vid_valid before an overrun is declared.
- AW, 19, RAM word-address width.

Ports:
- clk_sys  in  1  master clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- vid_addr1  in  AW  first video word address; stable from vid_rd toggle until vid_valid.
- vid_addr2  in  AW  second video word address; same stability rule as vid_addr1.
- vid_rd  in  1  toggle; every edge requests one fetch pair.
- vid_dout1  out  16  data read from vid_addr1.
- vid_dout2  out  16  data read from vid_addr2.
- vid_valid  out  1  one-cycle pulse; both vid_dout words updated.
- cpu_req  in  1  level request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_addr  in  AW+1  byte address; bit 0 selects the byte lane (0 = [7:0]).
- cpu_din  in  8  write data.
- cpu_dout  out  8  read data; valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_wait  out  1  cpu_req & ~cpu_ack (combinational).
- ram_addr  out  AW  RAM word address.
- ram_req  out  1  held until ram_ack.
- ram_we  out  1  write strobe; qualified by ram_req.
- ram_be  out  2  byte enables; 2'b11 for reads.
- ram_din  out  16  cpu_din replicated on both bytes.
- ram_dout  in  16  read data; valid on the ram_ack cycle.
- ram_ack  in  1  access complete; minimum one cycle after ram_req rises.
- overrun  out  1  sticky video-deadline violation flag.

## Operation
- Toggle detect: vid_rd_d registers vid_rd. vid_rd != vid_rd_d sets vid_pend and loads the budget counter with VID_BUDGET.
- States:
  - IDLE: vid_pend → VID1; else cpu_req & ~cpu_busy_done → CPU.
  - VID1: ram_addr = vid_addr1, ram_req = 1. On ram_ack, latch vid_dout1 and go to VID2.
  - VID2: ram_addr = vid_addr2. On ram_ack, latch vid_dout2, pulse vid_valid, clear vid_pend. If cpu_req, go to CPU; else go to IDLE.
  - CPU: ram_addr = cpu_addr[AW:1], ram_we = cpu_we, ram_be = cpu_addr[0] ? 2'b10 : 2'b01 for writes. On ram_ack, pulse cpu_ack, take cpu_dout from the selected ram_dout byte, and go to IDLE.
- Priority: video over CPU in IDLE. After a completed video pair, a pending CPU request is always served next (anti-starvation). An access already in progress is never pre-empted.
- CPU handshake: the requester drops cpu_req in the cycle after cpu_ack. A level still high in that cycle is ignored (cpu_busy_done), so one request yields one access.
- Overrun:
  - The budget counter decrements each cycle while vid_pend is set. Reaching 0 before vid_valid sets overrun.
  - A new vid_rd toggle while vid_pend is still set also sets overrun. The pair in progress completes with the addresses present at that time; the new pending request is then served.
  - overrun clears only on reset.
- Reset:
  - All outputs 0, state IDLE, vid_pend 0.
  - vid_rd_d loads vid_rd, so there is no spurious request.
  - Reset mid-access drops ram_req in the same edge; any late ram_ack in IDLE is ignored.

## Timing
- Toggle on vid_rd in cycle t → ram_req with vid_addr1 at t+2 if IDLE (t+1 registers detect, t+2 state VID1).
- ram_ack of the first read in cycle a → ram_req with vid_addr2 at a+1 (back-to-back).
- ram_ack of the second read in cycle b → vid_valid and vid_dout2 valid at b+1.
- CPU latency: cpu_req seen in IDLE at cycle c → ram_req at c+1 → cpu_ack at ack+1.
- With a 1-cycle-ack RAM, a video pair takes 6 cycles, well inside the default budget.

## Configuration
- VRAM_ARB_STATS_EN defined: adds output cpu_wait_cnt[15:0], a saturating count of cycles with cpu_wait high. It is cleared by reset and by an input stats_clr.
- Not defined: the port and counter are absent and stats_clr is not present. Functional behaviour is identical.

## Structure
- Package sam_vram_pkg contains:
  - typedef enum logic [1:0] {IDLE, VID1, VID2, CPU} arb_state_t;
  - localparam VRAM_AW = 19, the default for AW.
- One sub-module, vram_arb_stats, holds the saturating counter. It is instantiated only under VRAM_ARB_STATS_EN.

## Test plan
- Single vid_rd toggle, 1-cycle-ack RAM, addr1=0x12340, addr2=0x12342 → two reads in order; vid_valid 6 cycles after the toggle with correct words; overrun=0.
- cpu_req read at byte 0x00005, RAM word 0xBEEF → ram_addr 0x00002, cpu_dout 0xBE, exactly one cpu_ack; cpu_wait high until the ack.
- cpu_req write 0x5A at 0x00004 and vid_rd toggle in the same cycle → video pair first, then ram_we with ram_be 2'b01 and ram_din 0x5A5A.
- RAM ack delayed 20 cycles per access → overrun set after 24 cycles; stays set until reset.
- Reset asserted while in VID2 with ram_req high → next cycle ram_req 0, state IDLE, no vid_valid; a stale ram_ack afterwards is ignored.
- With VRAM_ARB_STATS_EN, a 7-cycle CPU stall → cpu_wait_cnt = 7; stats_clr → 0.
